// File: rtl/regfile_dump_engine.sv
// rtl/regfile_dump_engine.sv - debug read-out engine streaming register file contents
//
// Takes over one register-file read port on a start pulse, walks indices
// 0..NUM_REGS-1 and emits each value as one beat on a valid/ready stream.
// Optional feature macro: REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum beat.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a dump (sampled only when idle)
//   busy     out  high while a dump is in progress
//   done     out  one-cycle pulse after the final beat's handshake
//   rf_req   out  read-port ownership request (core stalls while high)
//   rf_addr  out  register index driven to the read port
//   rf_data  in   combinational read data from the register file
//   m_data   out  stream data
//   m_valid  out  stream beat valid
//   m_ready  in   downstream accepts the beat
//   m_last   out  final beat of a dump
module regfile_dump_engine #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rf_req,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, FETCH, SEND, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  logic hs;
  assign hs = valid_q & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          idx_d   = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      FETCH: begin
        // rf_addr has been stable for this whole cycle, so rf_data is settled.
        data_d  = rf_data;
        valid_d = 1'b1;
        state_d = SEND;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        csum_d  = csum_q ^ rf_data;
        last_d  = 1'b0;
`else
        last_d  = (idx_q == LAST_IDX);
`endif
      end
      SEND: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            // csum_q already folds in the final data beat.
            state_d = CHK;
            data_d  = csum_q;
            valid_d = 1'b1;
            last_d  = 1'b1;
`else
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      CHK: begin
        if (hs) begin
          state_d = IDLE;
          idx_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign rf_req  = busy;
  assign rf_addr = idx_q;
  assign m_data  = data_q;
  assign m_valid = valid_q;
  assign m_last  = last_q;
  assign done    = done_q;

endmodule

// File: tb/tb_regfile_dump_engine.sv
// tb/tb_regfile_dump_engine.sv - scoreboard bench for regfile_dump_engine
module tb_regfile_dump_engine;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 8;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              m_ready = 1'b0;
  logic              busy, done, rf_req, m_valid, m_last;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data, m_data;

  logic [DATA_W-1:0] regs [NUM_REGS];
  assign rf_data = regs[rf_addr];

  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W:0] exp_q [$];
  logic [DATA_W:0] mon_exp;

  regfile_dump_engine #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rf_req(rf_req), .rf_addr(rf_addr), .rf_data(rf_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: one beat per register in index order, then the XOR of all of
  // them as a trailing beat when the checksum feature is built in.
  task automatic push_expected();
    logic [DATA_W-1:0] x;
    x = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      x = x ^ regs[i];
      exp_q.push_back({(i == NUM_REGS - 1) && (CHK == 0), regs[i]});
    end
    if (CHK != 0) exp_q.push_back({1'b1, x});
  endtask

  // Monitor: a beat transfers at the next rising edge when valid&ready now.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_unexpected: got 0x%0h expected none", m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat", {23'd0, m_last, m_data}, {23'd0, mon_exp});
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rf_req"}, rf_req, 0);
    check({tag, "_rf_addr"}, rf_addr, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
  endtask

  // bp_beat/bp_n: stall that beat for bp_n cycles; rs_beat: re-pulse start
  // while that beat is presented; rst_beat: reset while that beat is in SEND;
  // rnd: random m_ready; linger: idle cycles observed after done.
  task automatic dump(input int bp_beat, input int bp_n, input int rs_beat,
                      input int rst_beat, input bit rnd, input int linger);
    int e, hs, stalls, stall_left, done_e, done_n, req_gap, tog_err;
    bit hs_pend, hold, restarted;
    logic [DATA_W-1:0] pd;
    logic [ADDR_W-1:0] pa;
    logic pl;
    push_expected();
    start = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("rf_req_after_start", rf_req, 1);
    check("rf_addr_after_start", rf_addr, 0);
    check("m_valid_after_start", m_valid, 0);
    e = 0; hs = 0; stalls = 0; stall_left = bp_n; done_e = -1; done_n = 0;
    req_gap = 0; tog_err = 0; hs_pend = 0; hold = 0; restarted = 0;
    pd = '0; pa = '0; pl = 1'b0;
    while (e < 400) begin
      @(posedge clk); #1;
      e++;
      start = 1'b0;
      if (hs_pend) hs++;
      if (hold) begin
        check("hold_data", m_data, pd);
        check("hold_addr", rf_addr, pa);
        check("hold_last", m_last, pl);
        check("hold_valid", m_valid, 1);
      end
      if (m_valid && hs < NUM_REGS) check("rf_addr_beat", rf_addr, hs);
      if (done) begin
        done_n++;
        if (done_e < 0) done_e = e;
      end
      if (done_e >= 0 && e > done_e) begin
        check("idle_m_valid", m_valid, 0);
        check("idle_busy", busy, 0);
      end
      if (done_e < 0 && !rf_req) req_gap++;
      if (!rnd && bp_n == 0 && e < 2 * NUM_REGS && m_valid != (e % 2 == 1)) tog_err++;
      if (rst_beat >= 0 && m_valid && hs == rst_beat) begin
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (rs_beat >= 0 && !restarted && m_valid && hs == rs_beat) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (done_e >= 0 && e >= done_e + linger) break;
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      else if (m_valid && hs == bp_beat && stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else m_ready = 1'b1;
      hold = m_valid && !m_ready;
      if (hold) stalls++;
      hs_pend = m_valid && m_ready;
      pd = m_data; pa = rf_addr; pl = m_last;
    end
    check("done_seen", done_e >= 0, 1);
    check("done_edge", done_e, 2 * NUM_REGS + CHK + stalls);
    check("done_pulses", done_n, 1);
    check("beat_count", hs, NUM_REGS + CHK);
    check("rf_req_gap", req_gap, 0);
    check("queue_empty", exp_q.size(), 0);
    if (!rnd) begin
      check("stall_count", stalls, bp_n);
      check("valid_toggle", tog_err, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    regs[0] = 8'h00;
    for (int i = 1; i < NUM_REGS; i++) regs[i] = 8'(1 << (i - 1));

    dump(-1, 0, -1, -1, 1'b0, 0);
    check("busy_between", busy, 0);
    dump(-1, 0, -1, -1, 1'b0, 0);
    dump(3, 3, -1, -1, 1'b0, 2);
    dump(-1, 0, 2, -1, 1'b0, 4);
    dump(-1, 0, -1, 4, 1'b0, 0);
    dump(-1, 0, -1, -1, 1'b0, 2);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'($urandom);
      dump(-1, 0, -1, -1, 1'b1, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_dump_engine.md
# regfile_dump_engine

Debug read-out engine for the 8×8-bit CPU register file. On a start pulse it takes over one register-file read port, walks register indices 0..NUM_REGS-1, and emits each value as one beat on a valid/ready output stream toward the debug/trace link. It sits beside the core's register file, and the core stalls while `rf_req` is high.

## Interface
Parameters:
- `NUM_REGS`, 8: registers dumped, from index 0 to NUM_REGS-1.
- `ADDR_W`, 3: register index width; NUM_REGS ≤ 2^ADDR_W.
- `DATA_W`, 8: register and stream data width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `busy`  out  1  high from leaving IDLE until returning to IDLE.
- `done`  out  1  one-cycle pulse after the final beat's handshake.
- `rf_req`  out  1  port ownership request; the top level forces register-file read mode and stalls the core while high.
- `rf_addr`  out  ADDR_W  register index driven to the read port.
- `rf_data`  in  DATA_W  combinational read data from the register file.
- `m_data`  out  DATA_W  stream data.
- `m_valid`  out  1  stream beat valid.
- `m_ready`  in  1  downstream accepts the beat.
- `m_last`  out  1  marks the final beat of a dump.

## Operation
FSM states: IDLE, FETCH, SEND, CHK (CHK exists only with the macro). Index counter `idx` is ADDR_W bits wide.

- IDLE:
  - busy=0, rf_req=0, m_valid=0.
  - start=1 → FETCH; idx=0, rf_addr=0, rf_req=1, busy=1.
- FETCH (exactly 1 cycle):
  - rf_addr=idx is stable for the whole cycle.
  - At the end of the cycle, m_data←rf_data, m_valid←1, m_last←(idx==NUM_REGS-1 and no CHK), → SEND.
- SEND:
  - m_data, m_last and rf_addr are held stable while m_valid=1 and m_ready=0.
  - A handshake is m_valid&m_ready at a clock edge.
  - On a handshake with idx<NUM_REGS-1: idx←idx+1, rf_addr←idx+1, m_valid←0, → FETCH.
  - On a handshake with idx==NUM_REGS-1: → CHK (macro defined) or → IDLE with done=1, rf_req=0, busy=0, m_valid=0, m_last=0.
- CHK: m_data=checksum, m_valid=1, m_last=1. On a handshake → IDLE with done=1.
- `start` asserted while busy is ignored. No queuing, no restart.
- m_data holds its last value after a dump completes.
- R0 is dumped like every other register. The value is whatever the register file returns.
- Reset mid-operation:
  - Every output drops to its reset value immediately; the stream is abandoned without m_last.
  - After reset release, the next start dumps from index 0 again.
- Reset values: busy=0, done=0, rf_req=0, rf_addr=0, m_data=0, m_valid=0, m_last=0; state=IDLE, idx=0, checksum=0.

## Timing
- `start` high at edge 0 → rf_req/busy high after edge 0; first m_valid high after edge 1.
- With m_ready tied high, each beat costs 2 cycles (FETCH + SEND).
  - Without the macro: done pulses after edge 16, i.e. NUM_REGS*2 cycles after the start edge.
  - With the macro: add 1 cycle for CHK, so done pulses after edge 17.
- rf_data is sampled only at the end of FETCH. The register file must present valid data within one cycle of rf_addr changing.
- m_valid never drops without a handshake, except on reset.
- Backpressure adds cycles 1:1. No beat is lost or duplicated.

## Configuration
- Macro `REGFILE_DUMP_CHECKSUM_EN`.
- Defined:
  - An 8-bit running XOR of all dumped values, cleared on start.
  - It is appended as one extra CHK beat carrying m_last=1.
  - Data beats never assert m_last.
- Undefined:
  - No CHK state and no checksum register.
  - m_last is asserted on the NUM_REGS-1 data beat.

## Test plan
- Preload R1..R7 with 0x01,0x02,0x04,…,0x40, pulse start, m_ready=1 → beats 0x00,0x01,…,0x40 in order. Without the macro, m_last on beat 8 and done after edge 16; with the macro, a 9th beat 0x7F with m_last and done after edge 17.
- Same preload, m_ready=0 for 3 cycles while beat 3 is presented → m_data=0x04, m_valid=1, rf_addr=3 all stable for those cycles. Sequence unchanged, done delayed by exactly 3 cycles.
- Pulse start again at beat 2 → ignored. Exactly 8 data beats, one done pulse.
- Assert rst_n=0 while beat 4 is in SEND → all outputs 0 at once, no m_last. After release, start → full dump from 0x00.
- Back-to-back: start in the cycle after done → second dump is identical to the first, with busy low for exactly one cycle between dumps.
- m_ready held high throughout → rf_req continuously high from start until done, m_valid toggling 0/1 each cycle.
